fpnew_out_buffer: RTL and testbench
===================================

Name: fpnew_out_buffer

Overview:
- Output decoupling buffer placed directly downstream of the FPNew aux chain and lane pipelines.
- Captures each completed result with its status flags, tag and aux, and presents them on a ready/valid output port.
- Removes the combinational out_ready-to-in_ready path, so downstream backpressure no longer ripples through every pipeline stage.
- Supports flush and provides a busy indication for the operation group.

Parameters:
- Width, 64, result data width in bits.
- Depth, 2, number of buffer entries; legal range is 1 to 16. Any value outside this range is an elaboration error.
- FallThrough, 0, selects the empty-buffer path. 1: an input may appear on the output in the same cycle when the buffer is empty. 0: output is always registered.
- TagType, logic, type of the operation tag.
- AuxType, logic, type of the aux payload.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- result_i  in  Width  result from the lanes.
- status_i  in  5  fpnew_pkg::status_t flags {NV,DZ,OF,UF,NX}.
- tag_i  in  TagType  tag from the aux chain.
- aux_i  in  AuxType  aux from the aux chain.
- in_valid_i  in  1  upstream valid (aux chain out_valid_o).
- in_ready_o  out  1  buffer can accept an entry (feeds aux chain out_ready_i).
- flush_i  in  1  synchronous flush.
- result_o  out  Width  head result.
- status_o  out  5  head status.
- tag_o  out  TagType  head tag.
- aux_o  out  AuxType  head aux.
- out_valid_o  out  1  head entry valid.
- out_ready_i  in  1  downstream ready.
- busy_o  out  1  buffer holds at least one entry.

Behaviour:
- Storage: Depth-entry circular buffer.
  - rd_ptr and wr_ptr each range 0..Depth-1 and wrap from Depth-1 to 0; Depth need not be a power of two.
  - count ranges 0..Depth, width $clog2(Depth+1).
- Reset (rst_i=1 at a clock edge):
  - rd_ptr, wr_ptr and count are set to 0; storage entries are cleared to 0.
  - After reset: out_valid_o=0, busy_o=0, in_ready_o=1, result_o/status_o/tag_o/aux_o all 0.
  - rst_i has priority over flush_i and over any handshake in the same cycle.
- in_ready_o = (count != Depth). It depends only on registered state and never on out_ready_i, including when the buffer is full.
- Push: occurs when in_valid_i & in_ready_o. The inputs are written at wr_ptr, and wr_ptr advances.
- Pop: occurs when out_valid_o & out_ready_i. rd_ptr advances.
- Count update:
  - push only: count+1.
  - pop only: count-1.
  - push and pop together: count unchanged, both pointers advance. This is legal at any count from 1 to Depth-1. At count=Depth no push is possible.
- FallThrough=0:
  - out_valid_o = (count != 0).
  - Outputs show the entry at rd_ptr.
  - Minimum latency is 1 cycle: an entry pushed at edge N is visible after edge N.
- FallThrough=1:
  - When count=0 and in_valid_i=1: out_valid_o=1 and the outputs come combinationally from the inputs.
  - If out_ready_i=1 in that cycle, the entry passes through and is never stored; pointers and count do not change.
  - When count>0, behaviour is identical to FallThrough=0.
- Output stability: while out_valid_o=1 and out_ready_i=0, all head outputs hold stable. This does not apply to the combinational fall-through path, which follows the inputs.
- Flush (flush_i=1 at a clock edge):
  - Pointers and count are cleared; any push or pop in that cycle is discarded.
  - In the following cycle out_valid_o=0 and busy_o=0.
  - Combinational outputs during the flush cycle itself are unconstrained and must be ignored downstream.
- busy_o = (count != 0). With FallThrough=1, busy_o is also 1 during a pass-through cycle.
- No overflow or underflow is possible. A push when full or a pop when empty is blocked by the handshake; assertions flag any such attempt.

Test Plan:
- Reset then idle, Depth=2, FallThrough=0: hold rst_i=1 for 2 cycles -> out_valid_o=0, in_ready_o=1, busy_o=0, all outputs 0.
- Single transfer: push result=0x3FF0_0000_0000_0000, status=5'b00001, tag=3 with out_ready_i=1 -> out_valid_o=1 exactly one cycle later with identical fields. One cycle after that, busy_o=0.
- Backpressure and full, Depth=2:
  - Hold out_ready_i=0 and push A, B -> in_ready_o=0 after the second push; a third in_valid_i is held off.
  - Raise out_ready_i -> outputs A then B in order; in_ready_o returns to 1 the cycle after the first pop.
- Simultaneous push and pop at count=1, streamed for 20 cycles with Depth=3 -> count stays 1, pointers wrap 2->0 correctly, and the tag sequence 0..19 arrives in order with no gaps.
- Flush: fill with 2 entries, assert flush_i together with in_valid_i=1 -> next cycle out_valid_o=0, busy_o=0, and the flushed-cycle input is not output later.
- FallThrough=1, empty, in_valid_i=1 and out_ready_i=1 with tag=7 -> out_valid_o=1 and tag_o=7 in the same cycle; count remains 0.

Source files
------------

// File: rtl/fpnew_out_buffer.sv
// -----------------------------------------------------------------------------
// fpnew_out_buffer
//
// Output decoupling buffer that sits after the FPNew aux chain and the lane
// pipelines. Each completed result is captured together with its status flags,
// tag and aux payload, then offered on a ready/valid output port.
//
// in_ready_o depends only on the registered fill level. This cuts the
// combinational path from out_ready_i back into the pipelines.
//
// Parameters
//   Width       result width in bits
//   Depth       number of entries, 1..16; need not be a power of two
//   FallThrough 1: an empty buffer forwards the input in the same cycle
//               0: the output is always registered
//   TagType     operation tag type
//   AuxType     aux payload type
//
// Ports
//   clk_i, rst_i                      clock, synchronous active-high reset
//   result_i/status_i/tag_i/aux_i     entry from the lanes and aux chain
//   in_valid_i, in_ready_o            upstream handshake
//   flush_i                           synchronous flush of all entries
//   result_o/status_o/tag_o/aux_o     head entry
//   out_valid_o, out_ready_i          downstream handshake
//   busy_o                            buffer holds (or is passing) an entry
// -----------------------------------------------------------------------------
module fpnew_out_buffer #(
    parameter int unsigned Width       = 64,
    parameter int unsigned Depth       = 2,
    parameter bit          FallThrough = 1'b0,
    parameter type         TagType     = logic,
    parameter type         AuxType     = logic
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [Width-1:0] result_i,
    input  logic [4:0]       status_i,
    input  TagType           tag_i,
    input  AuxType           aux_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic             flush_i,
    output logic [Width-1:0] result_o,
    output logic [4:0]       status_o,
    output TagType           tag_o,
    output AuxType           aux_o,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic             busy_o
);

    if (Depth < 1 || Depth > 16) begin : g_depth_check
        $error("fpnew_out_buffer: Depth must be in 1..16");
    end

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);
    localparam logic [CntW-1:0] Full    = CntW'(Depth);

    // Storage
    logic [Width-1:0] result_q [Depth];
    logic [4:0]       status_q [Depth];
    TagType           tag_q    [Depth];
    AuxType           aux_q    [Depth];

    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0] count_q,  count_d;

    logic empty, ft_active, push, pop;

    assign empty = (count_q == '0);

    // Fall-through only ever engages on an empty buffer; otherwise the head
    // comes from storage so ordering is preserved.
    assign ft_active = FallThrough && empty && in_valid_i;

    assign in_ready_o  = (count_q != Full);
    assign out_valid_o = !empty || ft_active;
    assign busy_o      = !empty || ft_active;

    // A fall-through entry that is accepted downstream is never stored.
    assign push = in_valid_i && in_ready_o && !(ft_active && out_ready_i);
    assign pop  = !empty && out_ready_i;

    always_comb begin
        if (ft_active) begin
            result_o = result_i;
            status_o = status_i;
            tag_o    = tag_i;
            aux_o    = aux_i;
        end else begin
            result_o = result_q[rd_ptr_q];
            status_o = status_q[rd_ptr_q];
            tag_o    = tag_q[rd_ptr_q];
            aux_o    = aux_q[rd_ptr_q];
        end
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < Depth; i++) begin
                result_q[i] <= '0;
                status_q[i] <= '0;
                tag_q[i]    <= '0;
                aux_q[i]    <= '0;
            end
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            if (push && !flush_i) begin
                result_q[wr_ptr_q] <= result_i;
                status_q[wr_ptr_q] <= status_i;
                tag_q[wr_ptr_q]    <= tag_i;
                aux_q[wr_ptr_q]    <= aux_i;
            end
        end
    end

    // Overflow/underflow must be impossible through the handshake.
    a_no_overflow : assert property (@(posedge clk_i) disable iff (rst_i)
        push |-> (count_q != Full));
    a_no_underflow : assert property (@(posedge clk_i) disable iff (rst_i)
        pop |-> !empty);
    a_count_range : assert property (@(posedge clk_i) disable iff (rst_i)
        count_q <= Full);

endmodule

// File: tb/tb_fpnew_out_buffer.sv
module tb_fpnew_out_buffer;

    typedef logic [7:0] tag_t;
    typedef logic [3:0] aux_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] result_i;
    logic [4:0]  status_i;
    tag_t        tag_i;
    aux_t        aux_i;
    logic        flush;
    logic        out_ready;
    logic        iv0, iv1, iv2;

    // u0: Depth=2, FT=0   u1: Depth=3, FT=0   u2: Depth=2, FT=1
    logic [63:0] r0, r1, r2;
    logic [4:0]  s0, s1, s2;
    tag_t        t0, t1, t2;
    aux_t        a0, a1, a2;
    logic        ir0, ir1, ir2, ov0, ov1, ov2, bz0, bz1, bz2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fpnew_out_buffer #(.Width(64), .Depth(2), .FallThrough(1'b0), .TagType(tag_t), .AuxType(aux_t)) u0 (
        .clk_i(clk), .rst_i(rst), .result_i(result_i), .status_i(status_i), .tag_i(tag_i), .aux_i(aux_i),
        .in_valid_i(iv0), .in_ready_o(ir0), .flush_i(flush), .result_o(r0), .status_o(s0), .tag_o(t0),
        .aux_o(a0), .out_valid_o(ov0), .out_ready_i(out_ready), .busy_o(bz0));

    fpnew_out_buffer #(.Width(64), .Depth(3), .FallThrough(1'b0), .TagType(tag_t), .AuxType(aux_t)) u1 (
        .clk_i(clk), .rst_i(rst), .result_i(result_i), .status_i(status_i), .tag_i(tag_i), .aux_i(aux_i),
        .in_valid_i(iv1), .in_ready_o(ir1), .flush_i(flush), .result_o(r1), .status_o(s1), .tag_o(t1),
        .aux_o(a1), .out_valid_o(ov1), .out_ready_i(out_ready), .busy_o(bz1));

    fpnew_out_buffer #(.Width(64), .Depth(2), .FallThrough(1'b1), .TagType(tag_t), .AuxType(aux_t)) u2 (
        .clk_i(clk), .rst_i(rst), .result_i(result_i), .status_i(status_i), .tag_i(tag_i), .aux_i(aux_i),
        .in_valid_i(iv2), .in_ready_o(ir2), .flush_i(flush), .result_o(r2), .status_o(s2), .tag_o(t2),
        .aux_o(a2), .out_valid_o(ov2), .out_ready_i(out_ready), .busy_o(bz2));

    // One clock edge; inputs are changed and outputs sampled at the falling edge.
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0; iv0 = 1'b0; iv1 = 1'b0; iv2 = 1'b0;
        result_i = '0; status_i = '0; tag_i = '0; aux_i = '0;
        cyc(); cyc();
        rst = 1'b0;
        cyc();
        checks++; if (ov0 !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", ov0); end
        checks++; if (ir0 !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", ir0); end
        checks++; if (bz0 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bz0); end
        checks++; if ({r0, s0, t0, a0} !== '0) begin errors++;
            $display("FAIL reset_outputs got %h/%b/%h/%h exp all 0", r0, s0, t0, a0); end
        checks++; if (ov2 !== 1'b0 || bz2 !== 1'b0) begin errors++;
            $display("FAIL reset_ft_idle got valid %b busy %b exp 0 0", ov2, bz2); end
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        iv0 = 1'b1; result_i = 64'h3FF0_0000_0000_0000; status_i = 5'b00001; tag_i = 8'd3; aux_i = 4'd5;
        #1;
        checks++; if (ov0 !== 1'b0) begin errors++; $display("FAIL single_no_ft got %b exp 0", ov0); end
        cyc();
        iv0 = 1'b0; result_i = '0; status_i = '0; tag_i = '0; aux_i = '0;
        #1;
        checks++; if (ov0 !== 1'b1) begin errors++; $display("FAIL single_valid got %b exp 1", ov0); end
        checks++; if (r0 !== 64'h3FF0_0000_0000_0000 || s0 !== 5'b00001 || t0 !== 8'd3 || a0 !== 4'd5) begin
            errors++; $display("FAIL single_fields got %h/%b/%0d/%0d exp 3ff0000000000000/00001/3/5", r0, s0, t0, a0); end
        cyc();
        checks++; if (bz0 !== 1'b0 || ov0 !== 1'b0) begin errors++;
            $display("FAIL single_drain got busy %b valid %b exp 0 0", bz0, ov0); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        iv0 = 1'b1; tag_i = 8'd10; result_i = 64'hAAAA;
        cyc();
        checks++; if (ir0 !== 1'b1 || ov0 !== 1'b1 || t0 !== 8'd10) begin errors++;
            $display("FAIL bp_first got ready %b valid %b tag %0d exp 1 1 10", ir0, ov0, t0); end
        tag_i = 8'd11; result_i = 64'hBBBB;
        cyc();
        checks++; if (ir0 !== 1'b0) begin errors++; $display("FAIL bp_full_ready got %b exp 0", ir0); end
        // Third entry offered while full must be held off.
        tag_i = 8'd12; result_i = 64'hCCCC;
        cyc();
        checks++; if (ir0 !== 1'b0 || t0 !== 8'd10 || r0 !== 64'hAAAA) begin errors++;
            $display("FAIL bp_hold got ready %b tag %0d result %h exp 0 10 aaaa", ir0, t0, r0); end
        iv0 = 1'b0; out_ready = 1'b1;
        cyc();
        checks++; if (ir0 !== 1'b1 || ov0 !== 1'b1 || t0 !== 8'd11 || r0 !== 64'hBBBB) begin errors++;
            $display("FAIL bp_second got ready %b valid %b tag %0d exp 1 1 11", ir0, ov0, t0); end
        cyc();
        checks++; if (ov0 !== 1'b0 || bz0 !== 1'b0) begin errors++;
            $display("FAIL bp_empty got valid %b busy %b exp 0 0 (tag 12 must not enter)", ov0, bz0); end
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        int bad = 0;
        out_ready = 1'b0;
        iv1 = 1'b1; tag_i = 8'd0;
        cyc();
        out_ready = 1'b1;
        for (int i = 1; i < 20; i++) begin
            tag_i = tag_t'(i);
            #1;
            checks++;
            if (ov1 !== 1'b1 || t1 !== tag_t'(i - 1) || bz1 !== 1'b1 || ir1 !== 1'b1) begin
                errors++; bad++;
                $display("FAIL b2b_step%0d got valid %b tag %0d busy %b ready %b exp 1 %0d 1 1",
                         i, ov1, t1, bz1, ir1, i - 1);
            end
            cyc();
        end
        iv1 = 1'b0;
        #1;
        checks++; if (ov1 !== 1'b1 || t1 !== 8'd19) begin errors++;
            $display("FAIL b2b_last got valid %b tag %0d exp 1 19", ov1, t1); end
        cyc();
        checks++; if (ov1 !== 1'b0 || bz1 !== 1'b0) begin errors++;
            $display("FAIL b2b_drain got valid %b busy %b exp 0 0", ov1, bz1); end
        out_ready = 1'b0;
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        iv0 = 1'b1; tag_i = 8'd20;
        cyc();
        tag_i = 8'd21;
        cyc();
        checks++; if (ir0 !== 1'b0) begin errors++; $display("FAIL flush_prefill got ready %b exp 0", ir0); end
        tag_i = 8'd22; flush = 1'b1;
        cyc();
        flush = 1'b0; iv0 = 1'b0;
        #1;
        checks++; if (ov0 !== 1'b0 || bz0 !== 1'b0 || ir0 !== 1'b1) begin errors++;
            $display("FAIL flush_clear got valid %b busy %b ready %b exp 0 0 1", ov0, bz0, ir0); end
        out_ready = 1'b1;
        cyc(); cyc();
        checks++; if (ov0 !== 1'b0) begin errors++;
            $display("FAIL flush_no_ghost got valid %b tag %0d exp valid 0", ov0, t0); end
        out_ready = 1'b0;
    endtask

    task automatic test_fallthrough();
        out_ready = 1'b1; iv2 = 1'b1; tag_i = 8'd7; result_i = 64'h1234; aux_i = 4'd9;
        #1;
        checks++; if (ov2 !== 1'b1 || t2 !== 8'd7 || r2 !== 64'h1234 || a2 !== 4'd9 || bz2 !== 1'b1) begin errors++;
            $display("FAIL ft_pass got valid %b tag %0d result %h aux %0d busy %b exp 1 7 1234 9 1", ov2, t2, r2, a2, bz2); end
        cyc();
        iv2 = 1'b0;
        #1;
        checks++; if (ov2 !== 1'b0 || bz2 !== 1'b0 || ir2 !== 1'b1) begin errors++;
            $display("FAIL ft_not_stored got valid %b busy %b ready %b exp 0 0 1", ov2, bz2, ir2); end
        // Blocked fall-through entry must be captured and held.
        out_ready = 1'b0; iv2 = 1'b1; tag_i = 8'd8;
        #1;
        checks++; if (ov2 !== 1'b1 || t2 !== 8'd8) begin errors++;
            $display("FAIL ft_blocked got valid %b tag %0d exp 1 8", ov2, t2); end
        cyc();
        iv2 = 1'b0; tag_i = 8'd0;
        #1;
        checks++; if (ov2 !== 1'b1 || t2 !== 8'd8 || bz2 !== 1'b1) begin errors++;
            $display("FAIL ft_stored got valid %b tag %0d busy %b exp 1 8 1", ov2, t2, bz2); end
        out_ready = 1'b1;
        cyc();
        checks++; if (ov2 !== 1'b0 || bz2 !== 1'b0) begin errors++;
            $display("FAIL ft_drain got valid %b busy %b exp 0 0", ov2, bz2); end
        out_ready = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single();
        test_backpressure();
        test_back_to_back();
        test_flush();
        test_fallthrough();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
